// File: rtl/conv_mac_sequencer_if.sv
// Memory, MAC and result-stream signals for the convolution MAC sequencer.
// The master side is the sequencer; the slave side is the surrounding system
// (sample/weight memories, the external MAC and the result consumer).
interface conv_mac_sequencer_if #(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int XAW  = 4,
    parameter int WAW  = 2
);
    logic        [XAW-1:0]  x_addr;
    logic signed [INW-1:0]  x_data;
    logic        [WAW-1:0]  w_addr;
    logic signed [INW-1:0]  w_data;
    logic signed [INW-1:0]  mac_input0;
    logic signed [INW-1:0]  mac_input1;
    logic signed [INW-1:0]  mac_init_value;
    logic                   mac_init_acc;
    logic                   mac_input_valid;
    logic signed [OUTW-1:0] mac_out;
    logic signed [OUTW-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output x_addr, input x_data,
        output w_addr, input w_data,
        output mac_input0, output mac_input1, output mac_init_value,
        output mac_init_acc, output mac_input_valid,
        input  mac_out,
        output out_data, output out_valid, input out_ready
    );

    modport slave (
        input  x_addr, output x_data,
        input  w_addr, output w_data,
        input  mac_input0, input mac_input1, input mac_init_value,
        input  mac_init_acc, input mac_input_valid,
        output mac_out,
        input  out_data, input out_valid, output out_ready
    );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Sequencer for a 1-D convolution y[j] = bias + sum_k x[j+k]*w[k] computed on
// an external registered MAC. Each output takes INIT, K-1 FETCH cycles, one
// DRAIN cycle and at least one OUT cycle. Memory reads have one cycle of
// latency, so mac_input_valid is the issue strobe delayed by one cycle.
// K must be at least 2.
module conv_mac_sequencer #(
    parameter int INW  = 16,
    parameter int OUTW = 64,
    parameter int K    = 4,
    parameter int N    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic signed [INW-1:0] bias,
    output logic                  busy,
    output logic                  done,
    conv_mac_sequencer_if.master  bus
);
    localparam int XAW = $clog2(N + K - 1);
    localparam int WAW = $clog2(K);
    localparam int JW  = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [JW-1:0]         j_q, j_d;
    logic [WAW-1:0]        k_q, k_d;
    logic signed [INW-1:0] init_value_q, init_value_d;
    logic                  valid_q;
    logic                  done_q, done_d;
    logic                  issue;

    // State and datapath registers; the issue strobe is delayed to line up with read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            j_q          <= '0;
            k_q          <= '0;
            init_value_q <= '0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            j_q          <= j_d;
            k_q          <= k_d;
            init_value_q <= init_value_d;
            valid_q      <= issue;
            done_q       <= done_d;
        end
    end

    // Next-state logic and all outputs derived from the current state.
    always_comb begin
        state_d      = state_q;
        j_d          = j_q;
        k_d          = k_q;
        init_value_d = init_value_q;
        done_d       = 1'b0;

        issue               = 1'b0;
        busy                = 1'b1;
        done                = done_q;
        bus.x_addr          = '0;
        bus.w_addr          = '0;
        bus.mac_init_acc    = 1'b0;
        bus.mac_input_valid = valid_q;
        bus.mac_input0      = bus.x_data;
        bus.mac_input1      = bus.w_data;
        bus.mac_init_value  = init_value_q;
        bus.out_valid       = 1'b0;
        bus.out_data        = bus.mac_out;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    init_value_d = bias;
                    j_d          = '0;
                    k_d          = '0;
                    state_d      = S_INIT;
                end
            end
            S_INIT: begin
                // Load the bias into the accumulator while tap 0 is fetched.
                bus.mac_init_acc = 1'b1;
                issue            = 1'b1;
                bus.x_addr       = XAW'(j_q);
                bus.w_addr       = '0;
                k_d              = WAW'(1);
                state_d          = S_FETCH;
            end
            S_FETCH: begin
                issue      = 1'b1;
                bus.x_addr = XAW'(j_q) + XAW'(k_q);
                bus.w_addr = k_q;
                if (k_q == WAW'(K - 1)) begin
                    k_d     = '0;
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                // Last tap's data is in flight; nothing new is issued.
                state_d = S_OUT;
            end
            S_OUT: begin
                // MAC is idle here, so mac_out (and out_data) holds steady.
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    if (j_q == JW'(N - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = S_INIT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
